uart_rx_param: RTL
==================

// Module: uart_rx_param
// PURPOSE
// Parametrised UART receiver: configurable clock/baud, data bits, parity and stop bits.
// Adds a 2-flop input synchroniser, mid-start-bit glitch rejection, parity/framing checks,
// break handling, and a valid/ready output handshake with an overrun flag.
// Sits between the board rx pin and a byte consumer (FIFO or command decoder).
// PARAMETERS
// CLK_HZ     1_000_000  system clock frequency in Hz
// BAUD       9600       line rate; BAUD_TICKS = CLK_HZ/BAUD (104), HALF = BAUD_TICKS/2 (52)
// DATA_BITS  8          data bits per frame, 5..9, sent LSB first
// PARITY     0          0 = none, 1 = even, 2 = odd
// STOP_BITS  1          1 or 2
// PORTS
// clk         in   1          system clock, rising edge
// rst         in   1          asynchronous, active-high reset
// rx          in   1          asynchronous serial line; idles high
// data_out    out  DATA_BITS  received word, valid while data_valid=1
// data_valid  out  1          word available; held until accepted
// data_ready  in   1          consumer accepts the word when data_valid & data_ready at a rising clk edge
// parity_err  out  1          parity mismatch for data_out; qualified by data_valid
// frame_err   out  1          a stop bit was sampled 0 for data_out; qualified by data_valid
// overrun     out  1          sticky: a frame was dropped because data_valid was not accepted
// busy        out  1          1 in any state except IDLE
// BEHAVIOUR
// - Reset: all outputs 0; sync flops 1; state IDLE; counters 0. Applies at once, including mid-frame.
// - Static checks: elaborate-time $error if BAUD_TICKS<4, DATA_BITS outside 5..9,
//   PARITY>2 or STOP_BITS outside 1..2.
// - rx passes through 2 flops to give rx_s. All decisions use rx_s only.
// - Bit counter: $clog2(BAUD_TICKS+1) bits wide, down-counting; a sample is taken when it reaches 0.
// - FSM states: IDLE, START, DATA, PAR, STOP, WAIT_HI.
//   IDLE:    rx_s==0 -> START, cnt=HALF-1.
//   START:   at cnt==0 sample rx_s.
//            1 -> glitch: back to IDLE, no output.
//            0 -> DATA, cnt=BAUD_TICKS-1, idx=0.
//   DATA:    at cnt==0 shift rx_s into bit idx (LSB first) and update running XOR.
//            After DATA_BITS samples -> PAR (if PARITY!=0) else STOP. Reload cnt=BAUD_TICKS-1 on every sample.
//   PAR:     sample the parity bit.
//            Even: error if XOR(data,par)!=0. Odd: error if XOR(data,par)!=1.
//   STOP:    sample STOP_BITS bits; any 0 sets the frame error.
//            After the last stop sample, complete the frame.
//            Next state is IDLE if no frame error, else WAIT_HI.
//   WAIT_HI: stay until rx_s==1, then -> IDLE. Prevents a held-low line (break) from retriggering.
// - Frame completion, in the cycle after the last stop sample:
//   If data_valid==0, or data_valid & data_ready in that same cycle:
//     load data_out, parity_err and frame_err; set data_valid=1.
//   Otherwise: discard the new frame, set overrun=1; data_out and the flags are unchanged.
// - Handshake: data_valid & data_ready -> data_valid=0 next cycle and overrun cleared,
//   unless a new frame loads in the same cycle (then data_valid stays 1).
// - data_valid may wait indefinitely. data_out and the flags are stable while data_valid=1.
// - Timing: start-bit sample is HALF clocks after START entry; each later sample is +BAUD_TICKS.
//   data_valid rises 1 clock after the final stop sample.
// - A 9-bit word with DATA_BITS=9 uses the full data_out width; PARITY still covers all data bits.
// TESTING
// 1. Defaults, send 0xA5 8N1 at 104 clk/bit, data_ready=1
//    -> one data_valid pulse, data_out=0xA5, parity_err=0, frame_err=0.
// 2. rx low for 30 clocks then high
//    -> no data_valid; busy returns to 0 within 55 clocks; a following 0x3C frame is received correctly.
// 3. PARITY=1 (even), send 0x03 with parity bit 1
//    -> data_out=0x03, parity_err=1. Same with parity bit 0 -> parity_err=0.
//    PARITY=2 (odd) inverts both results.
// 4. Break: rx low for 20 bit times, then high
//    -> exactly one word: data_out=0x00, frame_err=1.
//    The next 0x5A frame is received with frame_err=0.
// 5. data_ready=0, send 0x11 then 0x22
//    -> data_out stays 0x11, overrun=1.
//    One data_ready cycle -> data_valid=0 and overrun=0.
//    Repeat with data_ready asserted in the completion cycle -> 0x22 loaded, no overrun.
// 6. Assert rst during data bit 3 of a frame
//    -> all outputs 0 immediately.
//    After release, a full 0xC3 frame is received correctly (STOP_BITS=2 variant also run).

Source files
------------

// File: rtl/uart_rx_param.sv
// UART receiver with a 2-flop input synchroniser, start-bit glitch rejection,
// parity/framing checks, break handling and a valid/ready output with overrun.
module uart_rx_param #(
  parameter int CLK_HZ    = 1_000_000,
  parameter int BAUD      = 9600,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy,
  output logic [2:0]           dbg_state_o
);

  localparam int BAUD_TICKS = CLK_HZ / BAUD;
  localparam int HALF       = BAUD_TICKS / 2;
  localparam int CW         = $clog2(BAUD_TICKS + 1);

  localparam logic [CW-1:0] CNT_FULL  = CW'(BAUD_TICKS - 1);
  localparam logic [CW-1:0] CNT_HALF  = CW'(HALF - 1);
  localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);

  if (BAUD_TICKS < 4) begin : g_bad_baud
    $error("uart_rx_param: CLK_HZ/BAUD must be at least 4");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
    $error("uart_rx_param: DATA_BITS must be 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_rx_param: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_rx_param: STOP_BITS must be 1 or 2");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_WAIT_HI
  } state_t;

  state_t                 state_q;
  logic                   rx_meta_q, rx_s_q;
  logic [CW-1:0]          cnt_q;
  logic [3:0]             idx_q;
  logic [DATA_BITS-1:0]   shift_q;
  logic                   xor_q, perr_q, ferr_q, done_q;

  assign busy        = (state_q != S_IDLE);
  assign dbg_state_o = state_q;

  // Output handshake: a word is transferred on any rising clk edge where
  // data_valid and data_ready are both 1; data_out and flags hold until then.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      rx_meta_q  <= 1'b1;
      rx_s_q     <= 1'b1;
      cnt_q      <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      xor_q      <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      done_q     <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      done_q    <= 1'b0;

      if (data_valid && data_ready) begin
        data_valid <= 1'b0;
        overrun    <= 1'b0;
      end
      // A finished frame either loads (slot free or being freed) or is dropped.
      if (done_q) begin
        if (!data_valid || data_ready) begin
          data_out   <= shift_q;
          parity_err <= perr_q;
          frame_err  <= ferr_q;
          data_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end

      case (state_q)
        S_IDLE: begin
          if (!rx_s_q) begin
            state_q <= S_START;
            cnt_q   <= CNT_HALF;
          end
        end
        S_START: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CW'(1);
          end else if (rx_s_q) begin
            state_q <= S_IDLE;
          end else begin
            state_q <= S_DATA;
            cnt_q   <= CNT_FULL;
            idx_q   <= '0;
            xor_q   <= 1'b0;
          end
        end
        S_DATA: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CW'(1);
          end else begin
            shift_q <= {rx_s_q, shift_q[DATA_BITS-1:1]};
            xor_q   <= xor_q ^ rx_s_q;
            cnt_q   <= CNT_FULL;
            if (idx_q == LAST_DATA) begin
              idx_q   <= '0;
              perr_q  <= 1'b0;
              ferr_q  <= 1'b0;
              state_q <= (PARITY != 0) ? S_PAR : S_STOP;
            end else begin
              idx_q <= idx_q + 4'd1;
            end
          end
        end
        S_PAR: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CW'(1);
          end else begin
            perr_q  <= (PARITY == 1) ? (xor_q ^ rx_s_q) : ~(xor_q ^ rx_s_q);
            cnt_q   <= CNT_FULL;
            state_q <= S_STOP;
          end
        end
        S_STOP: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CW'(1);
          end else begin
            cnt_q <= CNT_FULL;
            if (!rx_s_q) ferr_q <= 1'b1;
            if (idx_q == LAST_STOP) begin
              done_q  <= 1'b1;
              cnt_q   <= '0;
              idx_q   <= '0;
              state_q <= (ferr_q || !rx_s_q) ? S_WAIT_HI : S_IDLE;
            end else begin
              idx_q <= idx_q + 4'd1;
            end
          end
        end
        S_WAIT_HI: begin
          // A held-low line (break) must go high before a new start is seen.
          if (rx_s_q) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
